// File: rtl/cube_check_pkg.sv
// Shared widths, FSM encoding and step count for the cube-root checker.
// Anything that must agree between the checker and its multiplier lives here.
package cube_check_pkg;

    localparam int DEF_A_W = 8;
    localparam int DEF_Y_W = 3;
    localparam int DEF_C_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQ_LO = 3'd1,
        CU_LO = 3'd2,
        SQ_HI = 3'd3,
        CU_HI = 3'd4,
        CMP   = 3'd5
    } state_t;

    // One shift-add step per bit of the widened multiplier y or y+1.
    function automatic int mul_steps(input int y_w);
        return y_w + 1;
    endfunction

endpackage

// File: rtl/cube_check_if.sv
// Request/result bundle between a cube-root stage and the checker.
// master drives the operands and start; slave returns status and results.
interface cube_check_if #(
    parameter int A_W = cube_check_pkg::DEF_A_W,
    parameter int Y_W = cube_check_pkg::DEF_Y_W,
    parameter int C_W = cube_check_pkg::DEF_C_W
);
    logic [A_W-1:0] a;
    logic [Y_W-1:0] y;
    logic           start;
    logic           busy;
    logic           done;
    logic           ok;
    logic [C_W-1:0] lower;
    logic [C_W-1:0] upper;

    modport master (output a, y, start, input busy, done, ok, lower, upper);
    modport slave  (input a, y, start, output busy, done, ok, lower, upper);
endinterface

// File: rtl/mul_shift_add.sv
// Sequential C_W x B_W shift-add multiplier, LSB first, B_W cycles including the start edge.
// start_i is taken only while idle; last_o flags the edge that completes the product.
module mul_shift_add
    import cube_check_pkg::*;
#(
    parameter int C_W = DEF_C_W,
    parameter int B_W = DEF_Y_W + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [C_W-1:0] mcand_i,
    input  logic [B_W-1:0] mplier_i,
    output logic           busy_o,
    output logic           last_o,
    output logic [C_W-1:0] prod_o
);
    localparam int CNT_W = $clog2(B_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

    logic [C_W-1:0]   mcand_q, mcand_d;
    logic [B_W-1:0]   mplier_q, mplier_d;
    logic [C_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            if (mplier_q[cnt_q]) begin
                acc_d = acc_q + (mcand_q << cnt_q);
            end
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (start_i) begin
            // The start edge doubles as step 0 so a product costs exactly B_W edges.
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = mplier_i[0] ? mcand_i : '0;
            cnt_d    = CNT_W'(1);
            busy_d   = 1'b1;
        end
    end

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == LAST);
    assign prod_o = acc_q;

endmodule

// File: rtl/cube_check.sv
// Checks y^3 <= a < (y+1)^3 with one shared multiplier; done 17 edges after an accepted start.
// start is ignored while busy, nothing is queued; results hold until the next accepted start.
module cube_check
    import cube_check_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int Y_W = DEF_Y_W,
    parameter int C_W = DEF_C_W
) (
    input  logic         clk,
    input  logic         rst,
    cube_check_if.slave  bus
);
    localparam int B_W = mul_steps(Y_W);

    if (C_W < 3 * B_W - 2) begin : g_width_check
        $error("cube_check: C_W too narrow for (2^Y_W)^3");
    end

    state_t         state_q, state_d;
    logic [A_W-1:0] a_q, a_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           done_q, done_d;
    logic           ok_q, ok_d;
    logic [C_W-1:0] lower_q, lower_d;
    logic [C_W-1:0] upper_q, upper_d;

    logic           mul_start, mul_busy, mul_last;
    logic [C_W-1:0] mul_mcand, mul_prod, a_ext;
    logic [B_W-1:0] mul_mplier, b_lo, b_hi;
    logic           accept;

    assign accept = (state_q == IDLE) && bus.start;
    assign b_lo   = {1'b0, y_q};
    assign b_hi   = b_lo + B_W'(1);
    assign a_ext  = C_W'(a_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SQ_LO;
            SQ_LO:   if (mul_last)  state_d = CU_LO;
            CU_LO:   if (mul_last)  state_d = SQ_HI;
            SQ_HI:   if (mul_last)  state_d = CU_HI;
            CU_HI:   if (mul_last)  state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The square from SQ_* is still in the multiplier when CU_* starts and becomes the multiplicand.
    always_comb begin
        mul_start  = 1'b0;
        mul_mcand  = '0;
        mul_mplier = b_lo;
        case (state_q)
            SQ_LO: begin
                mul_start = !mul_busy;
                mul_mcand = C_W'(b_lo);
            end
            CU_LO: begin
                mul_start = !mul_busy;
                mul_mcand = mul_prod;
            end
            SQ_HI: begin
                mul_start  = !mul_busy;
                mul_mcand  = C_W'(b_hi);
                mul_mplier = b_hi;
            end
            CU_HI: begin
                mul_start  = !mul_busy;
                mul_mcand  = mul_prod;
                mul_mplier = b_hi;
            end
            default: ;
        endcase
    end

    mul_shift_add #(
        .C_W (C_W),
        .B_W (B_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .mcand_i  (mul_mcand),
        .mplier_i (mul_mplier),
        .busy_o   (mul_busy),
        .last_o   (mul_last),
        .prod_o   (mul_prod)
    );

    always_comb begin
        a_d     = a_q;
        y_d     = y_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        lower_d = lower_q;
        upper_d = upper_q;
        if (accept) begin
            a_d = bus.a;
            y_d = bus.y;
        end
        // y^3 is captured on the first SQ_HI edge, before the multiplier is reused.
        if ((state_q == SQ_HI) && !mul_busy) begin
            lower_d = mul_prod;
        end
        // (y+1)^3 is still the multiplier's product here, so compare against it directly.
        if (state_q == CMP) begin
            upper_d = mul_prod;
            ok_d    = (lower_q <= a_ext) && (a_ext < mul_prod);
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            lower_q <= '0;
            upper_q <= '0;
        end else begin
            a_q     <= a_d;
            y_q     <= y_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            lower_q <= lower_d;
            upper_q <= upper_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.ok    = ok_q;
    assign bus.lower = lower_q;
    assign bus.upper = upper_q;

endmodule

// File: tb/tb_cube_check.sv
// Randomized bench for cube_check against a plain-arithmetic cube/bound model.
// Inputs change and outputs are sampled on the falling edge.
module tb_cube_check;
    localparam int A_W = 8;
    localparam int Y_W = 3;
    localparam int C_W = 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    cube_check_if #(.A_W(A_W), .Y_W(Y_W), .C_W(C_W)) bus ();

    cube_check #(.A_W(A_W), .Y_W(Y_W), .C_W(C_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cbrt_floor(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Waits for done starting just after the accept edge; cyc counts edges since that edge.
    task automatic wait_done(input bit disturb, output int cyc, output bit seen, output bit busy_bad);
        cyc      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && cyc < 40) begin
            if (disturb) begin
                bus.a     = A_W'($urandom);
                bus.y     = Y_W'($urandom);
                bus.start = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1'b1;
            else if (!bus.busy) busy_bad = 1'b1;
        end
    endtask

    task automatic run_op(input int av, input int yv, input bit disturb);
        int lo, hi, cyc;
        bit ok_e, seen, busy_bad;
        lo   = yv * yv * yv;
        hi   = (yv + 1) * (yv + 1) * (yv + 1);
        ok_e = (lo <= av) && (av < hi);
        @(negedge clk);
        bus.a     = av[A_W-1:0];
        bus.y     = yv[Y_W-1:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_on", bus.busy, 1);
        wait_done(disturb, cyc, seen, busy_bad);
        bus.start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", cyc, 17);
        check("busy_hold", busy_bad, 0);
        check("busy_off", bus.busy, 0);
        check("lower", bus.lower, lo);
        check("upper", bus.upper, hi);
        check("ok", bus.ok, ok_e);
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("no_queue", bus.busy, 0);
        check("lower_hold", bus.lower, lo);
        check("ok_hold", bus.ok, ok_e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc, dcnt;
        bit  seen, busy_bad;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        bus.a     = '0;
        bus.y     = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ok", bus.ok, 0);
        check("rst_lower", bus.lower, 0);
        check("rst_upper", bus.upper, 0);
        rst = 1'b1;

        run_op(0, 0, 0);
        run_op(27, 2, 0);
        run_op(27, 3, 0);
        run_op(255, 6, 0);
        run_op(200, 7, 0);
        run_op(100, 4, 1);

        // start held high straight through done: re-accepted on the edge after done
        @(negedge clk);
        bus.a     = 8'd10;
        bus.y     = 3'd2;
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(0, cyc, seen, busy_bad);
        check("held_lat1", cyc, 17);
        check("held_lower1", bus.lower, 8);
        @(negedge clk);
        check("held_reaccept", bus.busy, 1);
        check("held_done_drop", bus.done, 0);
        bus.start = 1'b0;
        wait_done(0, cyc, seen, busy_bad);
        check("held_lat2", cyc, 17);
        check("held_ok2", bus.ok, 1);
        check("held_upper2", bus.upper, 27);

        // reset in the middle of a check
        @(negedge clk);
        bus.a     = 8'd100;
        bus.y     = 3'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_ok", bus.ok, 0);
        check("abort_lower", bus.lower, 0);
        check("abort_upper", bus.upper, 0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check("abort_quiet", dcnt, 0);
        run_op(64, 4, 0);

        for (int av = 0; av < 256; av++) begin
            run_op(av, cbrt_floor(av), (av % 4) == 0);
        end

        repeat (60) begin
            run_op($urandom_range(0, 255), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cube_check.md
CUBE_CHECK -- requirements
Module: cube_check

Interface
REQ-001 Parameter A_W, default 8: width of operand a.
REQ-002 Parameter Y_W, default 3: width of candidate root y.
REQ-003 Parameter C_W, default 10: width of cube results; SHALL be at least 3*(Y_W+1)-2 bits, so it can hold (2^Y_W)^3.
REQ-004 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port a  input  A_W: value whose cube root is being checked.
REQ-007 Port y  input  Y_W: candidate root from the upstream cube-root stage (its res output).
REQ-008 Port start  input  1: request; sampled only when busy=0.
REQ-009 Port busy  output  1: check in progress.
REQ-010 Port done  output  1: one-cycle pulse when the results are valid.
REQ-011 Port ok  output  1: 1 when lower <= a < upper.
REQ-012 Port lower  output  C_W: y^3.
REQ-013 Port upper  output  C_W: (y+1)^3.

Function
REQ-014 When start=1 and busy=0 at a posedge, the block SHALL latch a and y, clear done, and set busy=1.
REQ-015 States SHALL be IDLE, SQ_LO, CU_LO, SQ_HI, CU_HI, CMP.
  Transitions: IDLE->SQ_LO on an accepted start; each SQ/CU state runs 4 steps, then advances in order; CMP->IDLE after 1 cycle.
REQ-016 The multiplier operand b SHALL be zero-extended to Y_W+1 bits: b=y in the LO states and b=y+1 in the HI states, with no wrap (y=7 gives b=8).
REQ-017 Each multiply SHALL be sequential shift-add over the Y_W+1 bits of b, LSB first, one bit per cycle: if bit k is set, acc += mcand<<k.
  Accumulator width is C_W.
REQ-018 SQ SHALL compute b*b; CU SHALL compute (b*b)*b.
  The CU_LO result SHALL be written to lower and the CU_HI result to upper.
REQ-019 CMP SHALL compute ok = (lower <= a) && (a < upper), using an unsigned compare with a zero-extended to C_W bits.
  In the same edge it SHALL set done=1 and busy=0.
REQ-020 Latency: with start accepted at edge T, busy SHALL be 1 from T through T+16, and done=1 with busy=0 in the cycle following edge T+17.
  Total busy time is 17 cycles (16 multiply steps plus 1 compare).
REQ-021 done SHALL be high for exactly one cycle. lower, upper and ok SHALL hold their values until the next accepted start.
REQ-022 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-023 Changes on a and y while busy=1 SHALL NOT affect the result.
REQ-024 start held high across done SHALL be accepted on the first edge where busy=0, which is the edge after done rises.

Reset
REQ-025 On rst=0 the block SHALL asynchronously force state=IDLE and busy=0, done=0, ok=0, lower=0, upper=0, and clear the accumulator and step counter.
REQ-026 A reset mid-operation SHALL abort the check with no done pulse.
  After rst returns to 1, the first posedge with start=1 SHALL begin a fresh check.

Structure
REQ-027 State encodings, the step count (Y_W+1) and the default widths SHALL live in the shared defines header.
  The adder-style stages include this header.
REQ-028 One sub-module, mul_shift_add, SHALL be used: a sequential C_W x (Y_W+1) multiplier with start/busy handshake.
  cube_check instantiates it once and reuses it for all four products.

Verification
REQ-029 a=0, y=0, start pulse -> done after 17 cycles; lower=0, upper=1, ok=1.
REQ-030 a=27, y=2 -> lower=8, upper=27, ok=0 (upper bound is exclusive).
  Then a=27, y=3 -> lower=27, upper=64, ok=1.
REQ-031 a=255, y=6 -> lower=216, upper=343, ok=1.
  Then a=200, y=7 -> lower=343, upper=512, ok=0 (no wrap on y+1).
REQ-032 Start a=100, y=4; pulse start again and change a=5 at busy cycle 5 -> exactly one done, with lower=64, upper=125, ok=1.
REQ-033 Start a=100, y=4; drive rst=0 at busy cycle 8 -> outputs are 0 immediately and no done occurs.
  After release, a=64, y=4 -> ok=1 after 17 cycles.
REQ-034 Sweep a=0..255, each paired with a reference cube root -> ok=1 for every a, and each done exactly 17 cycles after its start.
